step_clock_ctrl: RTL and testbench
==================================

Name: step_clock_ctrl

Overview:
Parametrised run-control block for the board top level. It replaces the derived manual, slow and fast gated clocks with single-cycle clock-enable pulses on one clock domain, plus a free-running memory-enable tick. It adds a debounced step key, a burst-N mode, halt gating and an executed-cycle counter. The datapath consumes oCLKEn. The display mux shows oCycleCount.

Parameters:
SLOW_DIV, 10000000, iCLK cycles between enables in slow mode (>=2)
FAST_DIV, 31, iCLK cycles between enables in fast and burst mode (>=2)
MEM_DIV, 5, iCLK cycles between oMemEn pulses (>=2)
DEBOUNCE_CYC, 500000, cycles a synchronised key level must be stable before it is accepted (>=1)
CNT_W, 32, width of oCycleCount
BURST_W, 16, width of iBurstLen

Ports:
iCLK  in  1  system clock (50 MHz board clock)
iRST  in  1  asynchronous, active-low reset
iStepKey  in  1  raw push-button, active-low (pressed = 0)
iMode  in  2  00 manual, 01 slow, 10 fast, 11 burst
iBurstLen  in  BURST_W  number of enables per burst
iHalt  in  1  datapath halt request, active-high
iClrCount  in  1  synchronous clear of oCycleCount
oCLKEn  out  1  one-cycle datapath enable pulse
oMemEn  out  1  one-cycle memory enable pulse
oCycleCount  out  CNT_W  count of issued oCLKEn pulses
oRunning  out  1  auto or burst stepping is active
oBusy  out  1  burst in progress

Behaviour:
- Reset (iRST=0, async): all outputs 0; divider, debounce and burst counters 0; debounced key level = 1 (released); FSM = IDLE. All logic is on iCLK rising edge.
- Key path: 2-FF synchroniser, then a debounce counter. A synchronised level that differs from the debounced level for DEBOUNCE_CYC consecutive cycles replaces the debounced level. Any bounce restarts the count. A press event is the debounced 1->0 transition: one cycle wide, one event per press.
- Rate divider: counts 0..DIV-1. It ticks when count == DIV-1 and returns to 0. DIV is SLOW_DIV in slow mode and FAST_DIV in fast and burst mode. A registered change of iMode clears the divider in that cycle. After a change, the first tick comes DIV cycles later.
- Manual (00): press event in cycle N gives oCLKEn=1 in cycle N+1 only. iHalt does not block manual steps (debug single-step past a halt).
- Slow/fast (01/10): oCLKEn follows the divider tick, registered (one cycle later), while iHalt=0. With iHalt=1, ticks are dropped and the divider keeps running. oRunning = !iHalt in these modes.
- Burst (11), FSM IDLE/RUN:
  - IDLE + press event + iBurstLen != 0: load rem = iBurstLen, clear the divider, go to RUN.
  - iBurstLen == 0: ignore the press.
  - In RUN, each tick issues oCLKEn and decrements rem. When rem reaches 0 on a tick, that pulse is issued and the FSM returns to IDLE.
  - RUN -> IDLE with no further pulses on: press event (abort), iHalt=1, or a change of iMode.
  - oBusy = oRunning = (state==RUN).
- Outside burst mode the FSM is held in IDLE.
- oMemEn: free-running tick every MEM_DIV cycles, registered, independent of mode and halt. The first pulse comes MEM_DIV cycles after reset release.
- oCycleCount: +1 in the cycle after each oCLKEn. Wraps modulo 2^CNT_W. iClrCount has priority: if both apply in the same cycle, the result is 0.
- oCLKEn is never high on two consecutive cycles, because every divisor is >=2 and a press takes at least 2 cycles.
- Reset mid-burst or mid-debounce abandons all state immediately. No pulse is issued during reset or in the cycle of release.

Test Plan:
Bench overrides: SLOW_DIV=8, FAST_DIV=3, MEM_DIV=5, DEBOUNCE_CYC=4, CNT_W=8.
- Manual debounce: iMode=00; key low for 3 cycles, high for 2, then low for 10 -> exactly one oCLKEn, 1 cycle after the debounced event; oCycleCount=1. Release and press again -> oCycleCount=2.
- Slow/fast rate: iMode=01 for 40 cycles -> 5 pulses spaced 8 apart. Switch to 10 -> first pulse 3 (+1) cycles later, then every 3 cycles.
- Halt: iMode=10, iHalt=1 for 12 cycles -> no oCLKEn and oRunning=0. Release halt -> pulses resume on the next divider tick.
- Burst: iMode=11, iBurstLen=4, one press -> exactly 4 pulses 3 cycles apart, oBusy falls after the 4th, oCycleCount=4. iBurstLen=0 plus a press -> no pulse. A second press mid-burst after 2 pulses -> abort, total 2.
- Mem tick and counter: oMemEn pulses at cycles 5, 10, 15 after reset release. With oCycleCount=255, one more pulse -> 0. iClrCount coinciding with a pulse -> 0.
- Async reset: assert iRST=0 mid-burst between clock edges -> outputs 0 immediately; after release, no oCLKEn without a new press.

Source files
------------

// File: rtl/step_clock_ctrl.sv
// step_clock_ctrl: run control for the board top level on a single clock.
// It makes oCLKEn and oMemEn enable pulses, debounces the step key, and
// runs burst-N stepping with halt gating and an executed-cycle counter.
//
// Ports:
//   iCLK        system clock
//   iRST        asynchronous active-low reset
//   iStepKey    raw push-button, active-low
//   iMode       00 manual, 01 slow, 10 fast, 11 burst
//   iBurstLen   number of enables per burst
//   iHalt       datapath halt request
//   iClrCount   synchronous clear of oCycleCount
//   oCLKEn      one-cycle datapath enable
//   oMemEn      one-cycle free-running memory enable
//   oCycleCount count of issued oCLKEn pulses
//   oRunning    auto or burst stepping active
//   oBusy       burst in progress
module step_clock_ctrl #(
    parameter int SLOW_DIV     = 10000000,
    parameter int FAST_DIV     = 31,
    parameter int MEM_DIV      = 5,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int CNT_W        = 32,
    parameter int BURST_W      = 16
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iStepKey,
    input  logic [1:0]         iMode,
    input  logic [BURST_W-1:0] iBurstLen,
    input  logic               iHalt,
    input  logic               iClrCount,
    output logic               oCLKEn,
    output logic               oMemEn,
    output logic [CNT_W-1:0]   oCycleCount,
    output logic               oRunning,
    output logic               oBusy
);

    localparam int DMAX = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int DW   = $clog2(DMAX);
    localparam int MW   = $clog2(MEM_DIV);
    localparam int KW   = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [DW-1:0] SLOW_LAST = DW'(SLOW_DIV - 1);
    localparam logic [DW-1:0] FAST_LAST = DW'(FAST_DIV - 1);
    localparam logic [MW-1:0] MEM_LAST  = MW'(MEM_DIV - 1);
    localparam logic [KW-1:0] KEY_LAST  = KW'(DEBOUNCE_CYC - 1);

    localparam logic [1:0] M_MAN   = 2'b00;
    localparam logic [1:0] M_SLOW  = 2'b01;
    localparam logic [1:0] M_FAST  = 2'b10;
    localparam logic [1:0] M_BURST = 2'b11;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    // key path
    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d, deb_prev_q;
    logic [KW-1:0] dcnt_q, dcnt_d;
    logic          press;

    // mode, dividers, burst
    logic [1:0]         mode_q;
    logic               mode_chg;
    logic [DW-1:0]      div_q, div_d, div_last;
    logic               tick;
    logic [MW-1:0]      mdiv_q, mdiv_d;
    state_e             state_q, state_d;
    logic [BURST_W-1:0] rem_q, rem_d;
    logic               burst_start, burst_pulse;

    // outputs
    logic             clken_q, clken_d;
    logic             memen_q;
    logic             sfrun_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            deb_q      <= 1'b1;
            deb_prev_q <= 1'b1;
            dcnt_q     <= '0;
        end else begin
            sync1_q    <= iStepKey;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            dcnt_q     <= dcnt_d;
        end
    end

    // A differing level must hold for DEBOUNCE_CYC samples in a row;
    // any matching sample drops the count back to zero.
    always_comb begin
        deb_d  = deb_q;
        dcnt_d = '0;
        if (sync2_q != deb_q) begin
            if (dcnt_q == KEY_LAST) begin
                deb_d = sync2_q;
            end else begin
                dcnt_d = dcnt_q + KW'(1);
            end
        end
    end

    assign press = deb_prev_q & ~deb_q;

    assign mode_chg = (iMode != mode_q);
    assign div_last = (mode_q == M_SLOW) ? SLOW_LAST : FAST_LAST;
    assign tick     = (div_q == div_last);

    always_comb begin
        div_d = div_q + DW'(1);
        if (mode_chg || burst_start || tick) begin
            div_d = '0;
        end
    end

    assign mdiv_d = (mdiv_q == MEM_LAST) ? '0 : mdiv_q + MW'(1);

    // burst FSM: state register
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // burst FSM: next state
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        burst_start = 1'b0;
        burst_pulse = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (mode_q == M_BURST && !mode_chg && press
                    && iBurstLen != '0) begin
                    state_d     = S_RUN;
                    rem_d       = iBurstLen;
                    burst_start = 1'b1;
                end
            end
            S_RUN: begin
                // abort paths issue no further pulse
                if (mode_q != M_BURST || mode_chg || press || iHalt) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    burst_pulse = 1'b1;
                    rem_d       = rem_q - BURST_W'(1);
                    if (rem_q == BURST_W'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
    end

    // burst FSM and mode: output decode
    always_comb begin
        clken_d = 1'b0;
        unique case (mode_q)
            M_MAN:   clken_d = press;
            M_SLOW:  clken_d = tick & ~iHalt;
            M_FAST:  clken_d = tick & ~iHalt;
            M_BURST: clken_d = burst_pulse;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (iClrCount) begin
            cnt_d = '0;
        end else if (clken_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            mode_q  <= M_MAN;
            div_q   <= '0;
            mdiv_q  <= '0;
            clken_q <= 1'b0;
            memen_q <= 1'b0;
            sfrun_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            mode_q  <= iMode;
            div_q   <= div_d;
            mdiv_q  <= mdiv_d;
            clken_q <= clken_d;
            memen_q <= (mdiv_q == MEM_LAST);
            sfrun_q <= (iMode == M_SLOW || iMode == M_FAST) & ~iHalt;
            cnt_q   <= cnt_d;
        end
    end

    assign oCLKEn      = clken_q;
    assign oMemEn      = memen_q;
    assign oCycleCount = cnt_q;
    assign oBusy       = (state_q == S_RUN);
    assign oRunning    = sfrun_q | oBusy;

endmodule

// File: tb/tb_step_clock_ctrl.sv
// Testbench for step_clock_ctrl: directed vectors, corner sequences and a
// randomized run compared against a behavioural model.
module tb_step_clock_ctrl;

    localparam int SLOW = 8;
    localparam int FAST = 3;
    localparam int MEMD = 5;
    localparam int DEB  = 4;
    localparam int CW   = 8;
    localparam int BW   = 16;

    logic          iCLK = 1'b0;
    logic          iRST;
    logic          iStepKey;
    logic [1:0]    iMode;
    logic [BW-1:0] iBurstLen;
    logic          iHalt;
    logic          iClrCount;
    logic          oCLKEn;
    logic          oMemEn;
    logic [CW-1:0] oCycleCount;
    logic          oRunning;
    logic          oBusy;

    always #5 iCLK = ~iCLK;

    step_clock_ctrl #(
        .SLOW_DIV(SLOW), .FAST_DIV(FAST), .MEM_DIV(MEMD),
        .DEBOUNCE_CYC(DEB), .CNT_W(CW), .BURST_W(BW)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iStepKey(iStepKey), .iMode(iMode),
        .iBurstLen(iBurstLen), .iHalt(iHalt), .iClrCount(iClrCount),
        .oCLKEn(oCLKEn), .oMemEn(oMemEn), .oCycleCount(oCycleCount),
        .oRunning(oRunning), .oBusy(oBusy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic step();
        @(posedge iCLK);
        @(negedge iCLK);
    endtask

    task automatic do_reset();
        iRST      = 1'b0;
        iStepKey  = 1'b1;
        iMode     = 2'b00;
        iBurstLen = '0;
        iHalt     = 1'b0;
        iClrCount = 1'b0;
        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        iRST = 1'b1;
    endtask

    // ---------------- behavioural model ----------------
    // Key: raw level reaches the debouncer two samples late; the debounced
    // level flips once the last DEB samples all disagree with it.
    logic kq[$];
    logic hist[$];
    logic m_deb, m_press, m_clk, m_busy, m_sfrun, m_mem;
    logic [1:0] m_mode;
    int m_since, m_rem, m_cnt, m_edges;

    task automatic model_init();
        kq = {1'b1, 1'b1};
        hist.delete();
        m_deb = 1; m_press = 0; m_clk = 0; m_busy = 0;
        m_sfrun = 0; m_mem = 0; m_mode = 0;
        m_since = 0; m_rem = 0; m_cnt = 0; m_edges = 0;
    endtask

    task automatic model_step();
        int  div;
        bit  tk, chg, start, nclk, nbusy, allx;
        logic s;
        int  nrem;
        div   = (m_mode == 2'b01) ? SLOW : FAST;
        tk    = (m_since % div) == div - 1;
        chg   = (iMode != m_mode);
        start = 0;
        case (m_mode)
            2'b00:   nclk = m_press;
            2'b11:   nclk = m_busy && tk && !m_press && !iHalt && !chg;
            default: nclk = tk && !iHalt;
        endcase
        nbusy = m_busy;
        nrem  = m_rem;
        if (m_busy) begin
            if (m_press || iHalt || chg) nbusy = 0;
            else if (tk) begin
                nrem--;
                if (nrem == 0) nbusy = 0;
            end
        end else if (m_mode == 2'b11 && m_press && iBurstLen != 0 && !chg) begin
            nbusy = 1;
            nrem  = int'(iBurstLen);
            start = 1;
        end
        m_since = (chg || start) ? 0 : m_since + 1;
        if (iClrCount) m_cnt = 0;
        else if (m_clk) m_cnt = (m_cnt + 1) % 256;
        m_clk   = nclk;
        m_busy  = nbusy;
        m_rem   = nrem;
        m_mode  = iMode;
        m_sfrun = (iMode == 2'b01 || iMode == 2'b10) && !iHalt;
        m_edges++;
        m_mem   = (m_edges % MEMD) == 0;
        s = kq.pop_front();
        kq.push_back(iStepKey);
        hist.push_back(s);
        if (hist.size() > DEB) void'(hist.pop_front());
        m_press = 0;
        if (hist.size() == DEB) begin
            allx = 1;
            foreach (hist[i]) if (hist[i] == m_deb) allx = 0;
            if (allx) begin
                m_deb = ~m_deb;
                hist.delete();
                m_press = (m_deb == 0);
            end
        end
    endtask

    typedef struct {
        logic [1:0] mode;
        logic       halt;
        int         edges;
        int         pulses;
        int         count;
        logic       run;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int np, first, last, mode_left, key_left;
        bit seen, done;

        tbl[0] = '{2'b01, 1'b0, 41, 5, 4, 1'b1};
        tbl[1] = '{2'b10, 1'b0, 10, 3, 7, 1'b1};
        tbl[2] = '{2'b10, 1'b1, 12, 0, 8, 1'b0};
        tbl[3] = '{2'b10, 1'b0,  6, 2, 9, 1'b1};
        tbl[4] = '{2'b00, 1'b0, 10, 0, 10, 1'b0};
        tbl[5] = '{2'b11, 1'b0, 10, 0, 10, 1'b0};

        // reset state and memory tick
        iRST      = 1'b0;
        iStepKey  = 1'b1;
        iMode     = 2'b00;
        iBurstLen = '0;
        iHalt     = 1'b0;
        iClrCount = 1'b0;
        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        chk("rst_clken", oCLKEn, 0);
        chk("rst_memen", oMemEn, 0);
        chk("rst_count", oCycleCount, 0);
        chk("rst_running", oRunning, 0);
        chk("rst_busy", oBusy, 0);
        iRST = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step();
            chk($sformatf("memen_%0d", k), oMemEn, (k % MEMD) == 0);
        end

        // table of steady-mode windows
        do_reset();
        iBurstLen = 4;
        foreach (tbl[v]) begin
            iMode = tbl[v].mode;
            iHalt = tbl[v].halt;
            np = 0;
            for (int i = 0; i < tbl[v].edges; i++) begin
                step();
                if (oCLKEn) np++;
            end
            chk($sformatf("tbl%0d_pulses", v), np, tbl[v].pulses);
            chk($sformatf("tbl%0d_count", v), oCycleCount, tbl[v].count);
            chk($sformatf("tbl%0d_running", v), oRunning, tbl[v].run);
            chk($sformatf("tbl%0d_busy", v), oBusy, 0);
        end
        iHalt = 1'b0;

        // manual debounce
        iMode = 2'b00;
        iClrCount = 1'b1;
        step();
        iClrCount = 1'b0;
        repeat (4) step();
        np = 0;
        first = -1;
        for (int i = 0; i < 25; i++) begin
            iStepKey = (i < 3) ? 1'b0 : (i < 5) ? 1'b1 : (i < 15) ? 1'b0 : 1'b1;
            step();
            if (oCLKEn) begin
                np++;
                if (first < 0) first = i - 5;
            end
        end
        chk("man_pulses", np, 1);
        chk("man_latency", first, 6);
        chk("man_count1", oCycleCount, 1);
        for (int i = 0; i < 22; i++) begin
            iStepKey = (i < 10) ? 1'b0 : 1'b1;
            step();
        end
        chk("man_count2", oCycleCount, 2);

        // burst of 4
        iMode = 2'b11;
        iBurstLen = 4;
        iClrCount = 1'b1;
        step();
        iClrCount = 1'b0;
        repeat (4) step();
        np = 0; first = -1; last = -1;
        for (int i = 0; i < 40; i++) begin
            iStepKey = (i < 10) ? 1'b0 : 1'b1;
            step();
            if (oCLKEn) begin
                np++;
                if (first < 0) first = i;
                last = i;
            end
            if (i == 17) chk("burst_busy_hi", oBusy, 1);
            if (i == 18) chk("burst_busy_lo", oBusy, 0);
        end
        chk("burst_pulses", np, 4);
        chk("burst_first", first, 9);
        chk("burst_last", last, 18);
        chk("burst_count", oCycleCount, 4);

        // zero-length burst
        iBurstLen = 0;
        np = 0; seen = 0;
        for (int i = 0; i < 30; i++) begin
            iStepKey = (i < 10) ? 1'b0 : 1'b1;
            step();
            if (oCLKEn) np++;
            if (oBusy) seen = 1;
        end
        chk("len0_pulses", np, 0);
        chk("len0_busy", seen, 0);

        // abort by a second press after two pulses
        iBurstLen = 4;
        np = 0;
        for (int i = 0; i < 40; i++) begin
            iStepKey = (i < 4) ? 1'b0 : (i < 8) ? 1'b1 : (i < 18) ? 1'b0 : 1'b1;
            step();
            if (oCLKEn) np++;
            if (i == 13) chk("abort_busy_hi", oBusy, 1);
            if (i == 14) chk("abort_busy_lo", oBusy, 0);
        end
        chk("abort_pulses", np, 2);

        // counter wrap
        iClrCount = 1'b1;
        step();
        iClrCount = 1'b0;
        iBurstLen = 255;
        seen = 0; done = 0;
        for (int i = 0; i < 1200 && !done; i++) begin
            iStepKey = (i < 10) ? 1'b0 : 1'b1;
            step();
            if (oBusy) seen = 1;
            else if (seen) done = 1;
        end
        chk("wrap_burst_done", done, 1);
        iStepKey = 1'b1;
        step();
        chk("wrap_count255", oCycleCount, 255);
        iMode = 2'b00;
        repeat (3) step();
        for (int i = 0; i < 22; i++) begin
            iStepKey = (i < 10) ? 1'b0 : 1'b1;
            step();
        end
        chk("wrap_count0", oCycleCount, 0);

        // clear coinciding with a pulse
        iMode = 2'b10;
        np = 0;
        for (int i = 0; i < 20 && np < 2; i++) begin
            step();
            if (oCLKEn) np++;
        end
        chk("clr_pulses_seen", np, 2);
        iClrCount = 1'b1;
        step();
        iClrCount = 1'b0;
        chk("clr_priority", oCycleCount, 0);

        // async reset mid-burst
        iMode = 2'b11;
        iBurstLen = 50;
        repeat (4) step();
        for (int i = 0; i < 20; i++) begin
            iStepKey = (i < 10) ? 1'b0 : 1'b1;
            step();
        end
        chk("arst_pre_busy", oBusy, 1);
        #2 iRST = 1'b0;
        #1;
        chk("arst_clken", oCLKEn, 0);
        chk("arst_busy", oBusy, 0);
        chk("arst_running", oRunning, 0);
        chk("arst_count", oCycleCount, 0);
        chk("arst_memen", oMemEn, 0);
        step();
        step();
        iRST = 1'b1;
        np = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (oCLKEn) np++;
        end
        chk("arst_no_pulse", np, 0);

        // randomized run against the model
        do_reset();
        model_init();
        mode_left = 0;
        key_left  = 0;
        for (int c = 0; c < 4000; c++) begin
            if (mode_left == 0) begin
                iMode     = 2'($urandom_range(0, 3));
                iBurstLen = BW'($urandom_range(0, 6));
                mode_left = $urandom_range(15, 150);
            end
            mode_left--;
            if (key_left == 0) begin
                iStepKey = ~iStepKey;
                key_left = ($urandom_range(0, 3) == 0) ?
                           $urandom_range(1, 3) : $urandom_range(5, 20);
            end
            key_left--;
            if ($urandom_range(0, 40) == 0) iHalt = ~iHalt;
            iClrCount = ($urandom_range(0, 60) == 0);
            @(posedge iCLK);
            model_step();
            @(negedge iCLK);
            chk("rnd_clken", oCLKEn, m_clk);
            chk("rnd_memen", oMemEn, m_mem);
            chk("rnd_count", oCycleCount, m_cnt);
            chk("rnd_running", oRunning, m_sfrun | m_busy);
            chk("rnd_busy", oBusy, m_busy);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
